// File: rtl/aes_key_expander_pkg.sv
// Shared AES key-schedule types, constants and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int         AES_NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT      = 8'h01;

  typedef logic [127:0] rk_t;

  typedef enum logic {IDLE, EXPAND} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load control, status and round-key read port between key expander and cipher rounds.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic       start;
  rk_t        key_in;
  logic       busy;
  logic       done;
  logic       keys_valid;
  logic       rd_en;
  logic [3:0] rd_idx;
  rk_t        rk_out;

  modport master (
    output start, key_in, rd_en, rd_idx,
    input  busy, done, keys_valid, rk_out
  );

  modport slave (
    input  start, key_in, rd_en, rd_idx,
    output busy, done, keys_valid, rk_out
  );

endinterface

// File: rtl/aes_key_expander_round.sv
// Combinational AES-128 single-round key function: RotWord/SubWord/Rcon on w3, then the w0..w3 XOR chain.
module aes_key_expander_round
  import aes_pkg::*;
(
  input  logic        rst_i,
  input  rk_t         rk_i,
  input  logic [31:0] rcon_i,
  output rk_t         rk_o
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_i;
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  assign n0 = w0 ^ sub ^ rcon_i;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_o = rst_i ? '0 : {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key expansion: one round key per clock into an 11-entry flop bank,
// with a registered read port that stays usable while expansion is running.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic           clk,
  input  logic           reset,
  aes_key_expander_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcon_q, rcon_d;
  logic       done_q, done_d;
  logic       kv_q, kv_d;
  rk_t        rk_out_q, rk_out_d;
  logic       load, wr_en;
  logic [3:0] prev_idx;
  rk_t        prev_rk, next_rk;

  rk_t bank_q [NUM_ROUNDS+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = 4'd1;
          rcon_d  = RCON_INIT;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en  = 1'b1;
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          kv_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rcon_q   <= RCON_INIT;
      done_q   <= 1'b0;
      kv_q     <= 1'b0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rcon_q   <= rcon_d;
      done_q   <= done_d;
      kv_q     <= kv_d;
      rk_out_q <= rk_out_d;
    end
  end

  // Bank is deliberately not reset; its contents are meaningless until keys_valid.
  always_ff @(posedge clk) begin
    if (load) begin
      bank_q[0] <= bus.key_in;
    end else if (wr_en && cnt_q <= LAST) begin
      bank_q[cnt_q] <= next_rk;
    end
  end

  assign prev_idx = cnt_q - 4'd1;
  assign prev_rk  = (prev_idx <= LAST) ? bank_q[prev_idx] : '0;

  aes_key_expander_round u_round (
    .rst_i  (1'b0),
    .rk_i   (prev_rk),
    .rcon_i ({rcon_q, 24'h0}),
    .rk_o   (next_rk)
  );

  always_comb begin
    rk_out_d = rk_out_q;
    if (bus.rd_en) begin
      rk_out_d = (bus.rd_idx <= LAST) ? bank_q[bus.rd_idx] : '0;
    end
  end

  assign bus.busy       = (state_q == EXPAND);
  assign bus.done       = done_q;
  assign bus.keys_valid = kv_q;
  assign bus.rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench: FIPS-197 key schedule built from GF(2^8) arithmetic, compared against the bank.
module tb_aes_key_expander;

  logic clk;
  logic reset;

  aes_key_expander_if ifc();

  aes_key_expander dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pulse_start(input logic [127:0] key);
    ifc.start  = 1'b1;
    ifc.key_in = key;
    @(negedge clk);
    ifc.start  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (ifc.done !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    ifc.rd_en  = 1'b1;
    ifc.rd_idx = idx;
    @(negedge clk);
    ifc.rd_en  = 1'b0;
    val = ifc.rk_out;
  endtask

  task automatic verify_bank(input logic [127:0] key, input string name);
    logic [127:0] v;
    model_expand(key);
    check_eq({name, " keys_valid"}, 128'(ifc.keys_valid), 128'(1));
    for (int r = 0; r <= 10; r++) begin
      read_rk(4'(r), v);
      check_eq($sformatf("%s rk%0d", name, r), v, exp_rk[r]);
    end
  endtask

  task automatic run_expand(input logic [127:0] key, input string name);
    int cyc;
    pulse_start(key);
    check_eq({name, " busy after start"}, 128'(ifc.busy), 128'(1));
    wait_done(cyc);
    check_eq({name, " latency"}, 128'(cyc), 128'(10));
    @(negedge clk);
    check_eq({name, " done one cycle"}, 128'(ifc.done), 128'(0));
    check_eq({name, " busy after done"}, 128'(ifc.busy), 128'(0));
    verify_bank(key, name);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    logic [127:0] v, key_a, key_b;
    int cyc, pulses;

    reset       = 1'b1;
    ifc.start   = 1'b0;
    ifc.key_in  = '0;
    ifc.rd_en   = 1'b0;
    ifc.rd_idx  = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    check_eq("reset busy", 128'(ifc.busy), 128'(0));
    check_eq("reset done", 128'(ifc.done), 128'(0));
    check_eq("reset keys_valid", 128'(ifc.keys_valid), 128'(0));
    check_eq("reset rk_out", ifc.rk_out, 128'(0));
    reset = 1'b0;
    @(negedge clk);

    run_expand(FIPS_KEY, "fips");
    check_eq("fips rk1 literal", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("fips rk10 literal", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd1, v);
    check_eq("fips rk1 dut", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(4'd10, v);
    check_eq("fips rk10 dut", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    read_rk(4'd0, v);
    check_eq("rd idx0 key", v, FIPS_KEY);
    read_rk(4'd11, v);
    check_eq("rd idx11 zero", v, 128'(0));
    read_rk(4'd15, v);
    check_eq("rd idx15 zero", v, 128'(0));
    read_rk(4'd3, v);
    ifc.rd_idx = 4'd5;
    repeat (2) @(negedge clk);
    check_eq("rd_en low holds", ifc.rk_out, 128'ha0fafe1788542cb123a339392a6c7605 ^ 128'h0 ^ exp_rk[3] ^ 128'ha0fafe1788542cb123a339392a6c7605);

    run_expand(128'h0, "zero");
    read_rk(4'd1, v);
    check_eq("zero rk1 dut", v, 128'h62636363626363636263636362636363);
    read_rk(4'd10, v);
    check_eq("zero rk10 dut", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start re-pulsed while busy must be dropped
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = ~key_a;
    pulse_start(key_a);
    repeat (4) @(negedge clk);
    pulse_start(key_b);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.done === 1'b1) pulses++;
      @(negedge clk);
    end
    check_eq("restart ignored done count", 128'(pulses), 128'(1));
    verify_bank(key_a, "restart");

    // reset sampled at E6 aborts
    pulse_start(key_b);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort busy", 128'(ifc.busy), 128'(0));
    check_eq("abort done", 128'(ifc.done), 128'(0));
    check_eq("abort keys_valid", 128'(ifc.keys_valid), 128'(0));
    check_eq("abort rk_out", ifc.rk_out, 128'(0));
    reset = 1'b0;
    @(negedge clk);
    run_expand(FIPS_KEY, "post-abort");

    // back-to-back start in the done cycle, plus a read of rk10 in that same cycle
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_a);
    pulse_start(key_a);
    wait_done(cyc);
    check_eq("b2b first latency", 128'(cyc), 128'(10));
    ifc.rd_en  = 1'b1;
    ifc.rd_idx = 4'd10;
    pulse_start(key_b);
    ifc.rd_en  = 1'b0;
    check_eq("b2b done-cycle read rk10", ifc.rk_out, exp_rk[10]);
    check_eq("b2b keys_valid drops", 128'(ifc.keys_valid), 128'(0));
    check_eq("b2b busy rises", 128'(ifc.busy), 128'(1));
    wait_done(cyc);
    check_eq("b2b second latency", 128'(cyc), 128'(10));
    @(negedge clk);
    verify_bank(key_b, "b2b");

    for (int k = 0; k < 4; k++) begin
      key_a = {$urandom, $urandom, $urandom, $urandom};
      run_expand(key_a, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key-expansion controller. Accepts a 128-bit cipher key, iterates the existing single-round key function once per clock over 10 rounds, and stores all 11 round keys in an internal register bank. The bank is exposed through a registered read port to the downstream cipher round datapath. It sits between the key-load interface and the encryption/decryption rounds, and is the only producer of round keys in the design.

## Interface

Parameters:
- NUM_ROUNDS, 10: expansion rounds. Fixed for AES-128; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  single-cycle request to expand key_in; honoured only in IDLE
- key_in  input  128  cipher key, sampled on the start edge; word 0 is [127:96]
- busy  output  1  high while in EXPAND
- done  output  1  one-cycle pulse after round key 10 is written
- keys_valid  output  1  level; all 11 round keys are valid
- rd_en  input  1  read request
- rd_idx  input  4  round-key index, 0..10
- rk_out  output  128  registered read data

## Operation

- FSM states:
  - IDLE:
    - start=1 loads key_in into rk[0].
    - Sets cnt=1 and rcon=8'h01.
    - Clears keys_valid, then moves to EXPAND.
  - EXPAND, every cycle:
    - rk[cnt] = round(rk[cnt-1], {rcon,24'h0}).
    - rcon = xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
    - cnt = cnt+1.
    - On the write with cnt==10: set keys_valid=1, pulse done, return to IDLE.
- Round function, per round:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon.
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - RotWord is a left byte rotate: {w[23:0],w[31:24]}.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- start while busy is ignored; it is neither queued nor restarts the expansion.
- start in IDLE with keys_valid=1 re-expands. keys_valid drops on the start edge.
- Read port:
  - rd_en=1 with rd_idx≤10 gives rk_out=rk[rd_idx] on the next edge.
  - rd_idx 11..15 gives rk_out=0.
  - rd_en=0 holds rk_out.
  - Reads during EXPAND are legal and return current bank contents. Indices not yet written return stale data; consumers must gate on keys_valid.
- Reset:
  - Outputs: busy=0, done=0, keys_valid=0, rk_out=0.
  - State returns to IDLE; cnt=0, rcon=8'h01.
  - Bank contents are not cleared and are don't-care.
  - Reset mid-expansion aborts the expansion. done is not pulsed.

## Timing

- E0 = the edge sampling start. Edges E1..E10 write rk[1]..rk[10].
- busy is high from after E0 through E10, and low after E10.
- keys_valid and done go high after E10. done lasts exactly one cycle.
- Total latency is start to done in 10 cycles, 11 cycles including the load.
- A new start is accepted at E11 at the earliest, i.e. in the done cycle.
- Read latency is 1 cycle. A read issued in the done cycle of rk[10] returns the new value.
- Critical path: one S-box lookup plus the four-XOR word chain, from bank mux to bank write.

## Structure

- Shared package aes_pkg holds:
  - AES_NUM_ROUNDS=10 and RCON_INIT=8'h01.
  - xtime function.
  - Typedef for a 128-bit round key.
  - State enum {IDLE, EXPAND}.
- One sub-module: the existing round-key combinational block, instantiated once, with its reset input tied low. It contains the S-box.
- The bank is 11×128 flops, not RAM, so that reads remain legal during expansion.

## Test plan

- Key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - done exactly 10 cycles after E0.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk[1]=62636363626363636263636362636363.
  - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- start re-pulsed at E5 with a different key: ignored. Final keys match the first key, and done pulses once.
- reset asserted at E6:
  - busy, done, keys_valid and rk_out are 0 on the next cycle.
  - A subsequent start completes normally with the FIPS values.
- Read checks:
  - rd_idx=11 → rk_out=0.
  - rd_idx=0 after expansion → rk_out equals key_in.
  - rd_en=0 holds the previous rk_out.
- Back-to-back start in the done cycle:
  - keys_valid falls the next cycle and busy rises.
  - The second expansion completes in 10 cycles.
